// File: rtl/rs232_txd_param.sv
// rs232_txd_param: parametrised RS-232 transmitter with a one-word holding buffer.
// A second word can be queued while a frame is on the line. That word is then
// sent back-to-back with the current frame, with no idle gap between them.
//
// Parameters:
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = even, 2 = odd
//   STOP_BITS  stop bits per frame (1 or 2)
//   OVERSAMPLE clock cycles per bit (>= 2)
// Ports:
//   Clock16x  oversampled baud clock, rising edge
//   Reset     asynchronous active-high reset
//   Send      transmit request; only its rising edge matters
//   DataIn    word to send, sampled on the accept edge
//   Txd       serial line, idle high
//   Busy      high while a frame is on the line
//   Ready     high while the holding buffer is empty
//   Done      one-cycle pulse after a frame's last stop bit
module rs232_txd_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 Clock16x,
  input  logic                 Reset,
  input  logic                 Send,
  input  logic [DATA_BITS-1:0] DataIn,
  output logic                 Txd,
  output logic                 Busy,
  output logic                 Ready,
  output logic                 Done
);

  localparam int unsigned TW     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BC_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int unsigned BW     = (BC_MAX > 1) ? $clog2(BC_MAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 parity_q, parity_d;
  logic [DATA_BITS-1:0] buf_q, buf_d;
  logic                 buf_full_q, buf_full_d;
  logic                 send_q, send_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic                 bit_end;
  logic                 frame_end;

  // Parity bit for a word. Odd parity is the inverse of even parity.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return (^w) ^ 1'(PARITY == 2);
  endfunction

  assign accept    = Send & ~send_q & ready_q;
  assign bit_end   = (timer_q == TW'(OVERSAMPLE - 1));
  assign frame_end = (state_q == ST_STOP) && bit_end && (bitcnt_q == BW'(STOP_BITS - 1));

  // Next-state logic for the frame sequencer, the holding buffer and the registered outputs.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    parity_d   = parity_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    send_d     = Send;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d  = '0;
        bitcnt_d = '0;
        if (accept) begin
          shreg_d  = DataIn;
          parity_d = parity_of(DataIn);
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          timer_d  = '0;
          bitcnt_d = '0;
          state_d  = ST_DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          timer_d = '0;
          shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
          if (bitcnt_q == BW'(DATA_BITS - 1)) begin
            bitcnt_d = '0;
            state_d  = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          timer_d  = '0;
          bitcnt_d = '0;
          state_d  = ST_STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          timer_d = '0;
          if (frame_end) begin
            // Last stop bit is done. Chain the next word directly into a start bit, if one is waiting.
            done_d   = 1'b1;
            bitcnt_d = '0;
            if (buf_full_q) begin
              shreg_d    = buf_q;
              parity_d   = parity_of(buf_q);
              buf_full_d = 1'b0;
              state_d    = ST_START;
            end else if (accept) begin
              shreg_d  = DataIn;
              parity_d = parity_of(DataIn);
              state_d  = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        timer_d  = '0;
        bitcnt_d = '0;
      end
    endcase

    // A word that arrives mid-frame is parked in the buffer.
    if (accept && (state_q != ST_IDLE) && !frame_end) begin
      buf_d      = DataIn;
      buf_full_d = 1'b1;
    end

    busy_d  = (state_d != ST_IDLE);
    ready_d = ~buf_full_d;
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shreg_d[0];
      ST_PARITY: txd_d = parity_d;
      default:   txd_d = 1'b1;
    endcase
  end

  // State and output registers. SendQ resets high, so a Send held through reset is not seen as an edge.
  always_ff @(posedge Clock16x or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      send_q     <= 1'b1;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      parity_q   <= parity_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      send_q     <= send_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign Txd   = txd_q;
  assign Busy  = busy_q;
  assign Ready = ready_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_rs232_txd_param.sv
// Bench for rs232_txd_param. Four parameter sets run side by side against a frame-level reference model.
module tb_rs232_txd_param;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send  [N];
  logic [8:0] din   [N];
  logic       txd   [N];
  logic       busy  [N];
  logic       ready [N];
  logic       done  [N];

  always #5 clk = ~clk;

  rs232_txd_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) u_dut0 (
    .Clock16x(clk), .Reset(rst), .Send(send[0]), .DataIn(din[0][7:0]),
    .Txd(txd[0]), .Busy(busy[0]), .Ready(ready[0]), .Done(done[0]));
  rs232_txd_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16)) u_dut1 (
    .Clock16x(clk), .Reset(rst), .Send(send[1]), .DataIn(din[1][6:0]),
    .Txd(txd[1]), .Busy(busy[1]), .Ready(ready[1]), .Done(done[1]));
  rs232_txd_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)) u_dut2 (
    .Clock16x(clk), .Reset(rst), .Send(send[2]), .DataIn(din[2][6:0]),
    .Txd(txd[2]), .Busy(busy[2]), .Ready(ready[2]), .Done(done[2]));
  rs232_txd_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(4)) u_dut3 (
    .Clock16x(clk), .Reset(rst), .Send(send[3]), .DataIn(din[3][7:0]),
    .Txd(txd[3]), .Busy(busy[3]), .Ready(ready[3]), .Done(done[3]));

  int cfg_db [N];
  int cfg_par[N];
  int cfg_sb [N];
  int cfg_os [N];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a frame is a list of line bits, and each bit is held for OVERSAMPLE cycles.
  bit          m_act  [N];
  int          m_cyc  [N];
  int          m_len  [N];
  logic [15:0] m_frame[N];
  bit          m_bf   [N];
  logic [8:0]  m_buf  [N];
  bit          m_sp   [N];
  bit          m_txd  [N];
  bit          m_done [N];

  logic       nxt_rst;
  logic       nxt_send[N];
  logic [8:0] nxt_din [N];

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic build(input int i, input logic [8:0] w);
    logic [15:0] f;
    int          n;
    bit          p;
    f = '1;
    n = 0;
    p = 1'b0;
    f[n] = 1'b0;
    n++;
    for (int b = 0; b < cfg_db[i]; b++) begin
      f[n] = w[b];
      p ^= w[b];
      n++;
    end
    if (cfg_par[i] != 0) begin
      f[n] = (cfg_par[i] == 2) ? ~p : p;
      n++;
    end
    n += cfg_sb[i];
    m_frame[i] = f;
    m_len[i]   = n * cfg_os[i];
    m_cyc[i]   = 0;
    m_act[i]   = 1'b1;
  endtask

  task automatic model_reset(input int i);
    m_act[i]  = 1'b0;
    m_cyc[i]  = 0;
    m_bf[i]   = 1'b0;
    m_sp[i]   = 1'b1;
    m_txd[i]  = 1'b1;
    m_done[i] = 1'b0;
  endtask

  task automatic model_step(input int i);
    bit acc;
    acc     = send[i] && !m_sp[i] && !m_bf[i];
    m_sp[i] = send[i];
    m_done[i] = 1'b0;
    if (m_act[i] && m_cyc[i] == m_len[i]) begin
      m_done[i] = 1'b1;
      if (m_bf[i]) begin
        build(i, m_buf[i]);
        m_bf[i] = 1'b0;
      end else if (acc) begin
        build(i, din[i]);
      end else begin
        m_act[i] = 1'b0;
      end
    end else if (!m_act[i]) begin
      if (acc) build(i, din[i]);
    end else if (acc) begin
      m_buf[i] = din[i];
      m_bf[i]  = 1'b1;
    end
    if (m_act[i]) begin
      m_txd[i] = m_frame[i][m_cyc[i] / cfg_os[i]];
      m_cyc[i]++;
    end else begin
      m_txd[i] = 1'b1;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      chk_eq($sformatf("txd%0d", i),   int'(txd[i]),   int'(m_txd[i]));
      chk_eq($sformatf("busy%0d", i),  int'(busy[i]),  int'(m_act[i]));
      chk_eq($sformatf("ready%0d", i), int'(ready[i]), int'(!m_bf[i]));
      chk_eq($sformatf("done%0d", i),  int'(done[i]),  int'(m_done[i]));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    rst = nxt_rst;
    for (int i = 0; i < N; i++) begin
      send[i] = nxt_send[i];
      din[i]  = nxt_din[i];
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (rst) model_reset(i);
      else model_step(i);
    end
    #1;
    compare_all();
  endtask

  task automatic set_send(input logic v);
    for (int i = 0; i < N; i++) nxt_send[i] = v;
  endtask

  task automatic set_din(input logic [8:0] d);
    for (int i = 0; i < N; i++) nxt_din[i] = d;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < N; i++) nxt_din[i] = 9'($urandom);
      cycle();
    end
  endtask

  task automatic pulse_word(input logic [8:0] d, input int hold);
    set_din(d);
    set_send(1'b1);
    for (int c = 0; c < hold; c++) cycle();
    set_send(1'b0);
  endtask

  // Reset asserted between clock edges must take effect at once.
  task automatic reset_mid_cycle();
    #2;
    rst     = 1'b1;
    nxt_rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) model_reset(i);
    compare_all();
  endtask

  initial begin
    cfg_db  = '{8, 7, 7, 8};
    cfg_par = '{0, 1, 2, 0};
    cfg_sb  = '{1, 1, 1, 2};
    cfg_os  = '{16, 16, 16, 4};
    for (int i = 0; i < N; i++) begin
      send[i] = 1'b0;
      din[i]  = '0;
      model_reset(i);
    end
    nxt_rst = 1'b1;
    set_send(1'b0);
    set_din('0);

    run(3);
    nxt_rst = 1'b0;
    run(5);

    // Single frames with Send held for several cycles.
    pulse_word(9'h0AA, 4);
    run(180);
    pulse_word(9'h055, 2);
    run(180);
    pulse_word(9'h00F, 3);
    run(180);

    // Back-to-back: second word at cycle 64, third request at cycle 100 is dropped.
    for (int c = 0; c < 340; c++) begin
      for (int i = 0; i < N; i++) begin
        nxt_send[i] = (c < 2) || (c >= 64 && c < 66) || (c >= 100 && c < 102);
        nxt_din[i]  = (c == 0) ? 9'h0AA : (c == 64) ? 9'h00F : 9'($urandom);
      end
      cycle();
    end
    run(20);

    // Reset at cycle 50 with a word buffered, then a fresh frame.
    for (int c = 0; c < 50; c++) begin
      for (int i = 0; i < N; i++) begin
        nxt_send[i] = (c < 2) || (c >= 20 && c < 22);
        nxt_din[i]  = (c == 0) ? 9'h0AA : (c == 20) ? 9'h00F : 9'($urandom);
      end
      cycle();
    end
    reset_mid_cycle();
    run(2);
    nxt_rst = 1'b0;
    run(5);
    pulse_word(9'h03C, 2);
    run(180);

    // Send held high through reset release starts nothing until it falls and rises again.
    set_send(1'b1);
    nxt_rst = 1'b1;
    run(3);
    nxt_rst = 1'b0;
    run(20);
    set_send(1'b0);
    run(2);
    pulse_word(9'h1C3, 2);
    run(180);

    // Random traffic: random Send toggles and random data, independent per instance.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 11) == 0) nxt_send[i] = ~nxt_send[i];
        nxt_din[i] = 9'($urandom);
      end
      cycle();
    end
    set_send(1'b0);
    run(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs232_txd_param.md
# rs232_txd_param

Parametrised RS-232 transmitter: the next generation of the fixed 8N1 transmitter, with configurable data width, parity, stop bits and oversampling ratio. It adds a one-word holding buffer, so a second word can be queued while a frame is on the line and sent back-to-back with no idle gap. It sits between the host-side data path and the Txd pin, clocked by the oversampled baud clock.

## Interface

- DATA_BITS, 8, data bits per frame, legal 5..9
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, stop bits per frame, legal 1 or 2
- OVERSAMPLE, 16, clock cycles per bit, legal >= 2
- Clock16x  input  1  oversampled baud clock; the only clock; all logic on its rising edge
- Reset  input  1  asynchronous, active-high reset
- Send  input  1  transmit request; rising-edge detected internally; level is ignored
- DataIn  input  DATA_BITS  word to send; sampled only at the accept edge
- Txd  output  1  serial line, idle high
- Busy  output  1  high while a frame is on the line
- Ready  output  1  high while the holding buffer is empty
- Done  output  1  one-cycle pulse when a frame's final stop bit completes

## Operation

- Edge detect: register SendQ holds the previous Send. An accept occurs at a rising edge where Send=1, SendQ=0 and Ready=1. An edge with Ready=0 is dropped and is not remembered.
- On accept:
  - If the FSM is IDLE, DataIn loads straight into the shift register and the frame starts. The buffer stays empty and Ready stays 1.
  - Otherwise DataIn goes into the holding buffer and Ready goes to 0.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after OVERSAMPLE cycles.
  - DATA shifts LSB first. It leaves after DATA_BITS bit periods, to PARITY if PARITY != 0, else to STOP.
  - PARITY -> STOP after one bit period.
  - STOP lasts STOP_BITS bit periods.
- Line levels by state: START drives 0; DATA drives the shift-register LSB; STOP drives 1; IDLE drives 1.
- Parity bit:
  - Even: XOR of the data bits.
  - Odd: the inverse of that XOR.
- Frame end is the edge on which the last stop period completes. At that edge:
  - Done pulses.
  - If the buffer is full, the buffered word moves to the shift register, the FSM goes to START and Ready returns to 1. Txd goes directly from stop to start, with no idle cycle.
  - Else, if an accept happens in the same cycle, that word starts immediately in the same way.
  - Else the FSM goes to IDLE.
- Counters:
  - The bit-timer counts 0..OVERSAMPLE-1 and is sized ceil(log2(OVERSAMPLE)).
  - The bit counter is sized for max(DATA_BITS, STOP_BITS).
  - No counter wraps outside its state.
- A change on DataIn after the accept edge has no effect on the frame in progress or on the buffered word.

## Timing

- Reset values:
  - Txd=1, Busy=0, Ready=1, Done=0.
  - State IDLE, buffer empty, counters 0.
  - SendQ=1, so a Send held high through reset release does not trigger a frame.
- Reset mid-frame: Txd goes to 1 asynchronously. The frame and the buffered word are discarded and no Done is issued.
- Latency: the accept edge N in IDLE sets Txd=0 and Busy=1 from edge N.
- Frame length F = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) × OVERSAMPLE cycles. With the defaults F = 160.
- Done is high for exactly the one cycle after edge N+F. At edge N+F:
  - Busy returns to 0, unless a back-to-back frame starts.
  - In that case Busy stays 1 continuously.
- Ready falls on the edge that buffers a word. It rises on the edge that moves the word into the shift register.
- Send held high for several cycles produces exactly one accept.

## Test plan

- Defaults, DataIn=0xAA, Send pulsed high for 4 cycles -> Txd bits 0,0,1,0,1,0,1,0,1,1, each 16 cycles. Exactly one frame; Done at cycle 160; Busy low afterwards.
- DATA_BITS=7, PARITY=1, DataIn=0x55 -> parity bit 0, F=160. Repeat with PARITY=2 -> parity bit 1.
- STOP_BITS=2, OVERSAMPLE=4, DataIn=0x0F -> F=44 cycles; the last 8 cycles are high before Done.
- Back-to-back: 0xAA accepted, then 0x0F sent at cycle 64 -> Ready=0 from cycle 64. The second start bit follows the first stop bit with no gap; Ready=1 at cycle 160; Busy high for 320 cycles; two Done pulses. A third Send at cycle 100 is ignored.
- Reset asserted at cycle 50 of a frame, with a word buffered -> Txd=1 immediately, Busy=0, Ready=1, no Done. A fresh Send of 0x3C afterwards transmits correctly.
- Send held high through reset release -> no frame until Send falls and rises again.
